// File: rtl/mem_loader_pkg.sv
// Shared types and helpers for the byte-stream memory loader.
package mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_loader.sv
// Fills a single-port BRAM from a byte stream before the CPU runs,
// and passes the CPU memory port straight through when idle.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int AddrWidth = 8,
  parameter int DataWidth = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 Start,
  input  logic [AddrWidth-1:0] Base_Addr,
  input  logic [AddrWidth:0]   Word_Count,
  input  logic [7:0]           Byte_In,
  input  logic                 Byte_Valid,
  output logic                 Byte_Ready,
  input  logic [DataWidth-1:0] Cpu_DIn,
  input  logic [AddrWidth-1:0] Cpu_Address,
  input  logic                 Cpu_Write_EN,
  input  logic                 Cpu_Mem_En,
  output logic [DataWidth-1:0] Mem_DIn,
  output logic [AddrWidth-1:0] Mem_Address,
  output logic                 Mem_Write_EN,
  output logic                 Mem_Mem_En,
  output logic                 Cpu_Stall,
  output logic                 Busy,
  output logic                 Done,
  output logic [DataWidth-1:0] Checksum
);

  localparam int BPW = bytes_per_word(DataWidth);
  localparam int CntWidth = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [CntWidth-1:0] LastByte = CntWidth'(BPW - 1);
  localparam logic [AddrWidth:0] OneWord = (AddrWidth + 1)'(1);

  state_t                 state;
  state_t                 state_next;
  logic [AddrWidth-1:0]   addr;
  logic [AddrWidth:0]     remaining;
  logic [DataWidth-1:0]   word;
  logic [DataWidth-1:0]   word_shifted;
  logic [CntWidth-1:0]    byte_cnt;
  logic                   accept;
  logic                   start_load;
  logic                   start_empty;

  assign accept      = (state == COLLECT) && Byte_Valid;
  assign start_load  = (state == IDLE) && Start && (Word_Count != '0);
  assign start_empty = (state == IDLE) && Start && (Word_Count == '0);

  // Bytes arrive MSB-first, so each new byte shifts in at the bottom.
  generate
    if (DataWidth > 8) begin : g_shift
      assign word_shifted = {word[DataWidth-9:0], Byte_In};
    end else begin : g_single
      assign word_shifted = Byte_In;
    end
  endgenerate

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_load) begin
          state_next = COLLECT;
        end else if (start_empty) begin
          state_next = DONE;
        end
      end
      COLLECT: begin
        if (accept && (byte_cnt == LastByte)) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        state_next = (remaining == OneWord) ? DONE : COLLECT;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      byte_cnt  <= '0;
      Checksum  <= '0;
    end else if (start_load) begin
      addr      <= Base_Addr;
      remaining <= Word_Count;
      byte_cnt  <= '0;
      Checksum  <= '0;
    end else if (start_empty) begin
      Checksum  <= '0;
    end else if (accept) begin
      word      <= word_shifted;
      byte_cnt  <= (byte_cnt == LastByte) ? '0 : byte_cnt + 1'b1;
    end else if (state == WRITE) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
      Checksum  <= Checksum + word;
    end
  end

  // The loader owns the BRAM port whenever it is busy; enables are active-low.
  always_comb begin
    Mem_DIn      = Cpu_DIn;
    Mem_Address  = Cpu_Address;
    Mem_Write_EN = Cpu_Write_EN;
    Mem_Mem_En   = Cpu_Mem_En;
    if (state != IDLE) begin
      Mem_DIn      = word;
      Mem_Address  = addr;
      Mem_Write_EN = (state != WRITE);
      Mem_Mem_En   = (state != WRITE);
    end
  end

  assign Busy       = (state != IDLE);
  assign Cpu_Stall  = Busy;
  assign Done       = (state == DONE);
  assign Byte_Ready = (state == COLLECT);

endmodule
